tinker_regfile_sb: RTL and testbench
====================================

// Module: tinker_regfile_sb
// PURPOSE
//  Parametrised multi-port register file with scoreboard for the tinker core.
//  Read ports are combinational with write-first bypass; write ports are synchronous.
//  A per-register pending bit tracks registers owned by in-flight multi-cycle ops.
//  Sits between ID (reads, claims) and WB/long-latency units (writes that release claims).
// PARAMETERS
//  XLEN        64      register width in bits
//  NREG        32      number of architectural registers (power of 2)
//  NRD         3       number of read ports
//  NWR         2       number of write ports
//  SP_IDX      31      index of stack-pointer register
//  SP_INIT     524288  reset value of register SP_IDX
//  ZERO_REG_EN 0       1: register 0 reads 0, ignores writes and claims
// PORTS  (AW = $clog2(NREG))
//  clk        in   1         clock, all state updates on rising edge
//  reset      in   1         synchronous, active-high
//  rd_addr    in   NRD*AW    read addresses, port p at [p*AW +: AW]
//  rd_data    out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_busy    out  NRD       1 = addressed register pending, not released this cycle
//  wr_en      in   NWR       write enable per port
//  wr_addr    in   NWR*AW    write addresses
//  wr_data    in   NWR*XLEN  write data
//  wr_release in   NWR       1 = this write also clears the pending bit of wr_addr
//  claim_en   in   1         request to mark claim_addr pending
//  claim_addr in   AW        register to claim
//  claim_ok   out  1         claim accepted this cycle (combinational)
//  sp_val     out  XLEN      current value of register SP_IDX, with bypass
//  pend_vec   out  NREG      registered pending bits, for debug/hazard logic
// BEHAVIOUR
//  - Reset: regs[i] <= 0 for all i != SP_IDX; regs[SP_IDX] <= SP_INIT; pend_vec <= 0.
//    Writes and claims presented in a reset cycle are discarded.
//  - Outputs during/after reset follow combinationally from the reset state:
//    rd_data = reset contents, rd_busy = 0, claim_ok = claim_en.
//  - Write: on posedge, for each p with wr_en[p], regs[wr_addr[p]] <= wr_data[p].
//    Same address on several ports: highest-index port wins (data and release).
//  - Read (0 latency): rd_data[p] = data of highest-index enabled write port with
//    wr_addr == rd_addr[p], else regs[rd_addr[p]]. sp_val bypasses the same way.
//  - ZERO_REG_EN=1: reads of addr 0 return 0; rd_busy 0; writes/claims to 0 are no-ops
//    and claim_ok=1 for addr 0.
//  - Released set R = {wr_addr[p] : wr_en[p] & wr_release[p]}.
//    wr_release without wr_en is ignored.
//  - rd_busy[p] = pend_vec[rd_addr[p]] & ~(rd_addr[p] in R).
//  - claim_ok = claim_en & ~(pend_vec[claim_addr] & ~(claim_addr in R)).
//    Claiming an already-busy register is refused and pend_vec is unchanged.
//  - Pending update, in priority order:
//    claim_ok sets pend[claim_addr] (claim beats same-cycle release of the same reg);
//    otherwise addresses in R clear.
//  - Release of a non-pending register is legal and has no effect on pend_vec.
//    Its data is still written.
//  - No internal FSM beyond per-register pending state (IDLE <-> PENDING):
//    IDLE->PENDING on claim_ok; PENDING->IDLE on release without re-claim.
// TESTING
//  1. Reset: assert reset 1 cycle.
//     -> rd_data(addr 31) = 524288, rd_data(addr 5) = 0, pend_vec = 0.
//  2. Bypass: wr_en[0]=1, addr 3, data 0xDEAD, rd_addr[0]=3 same cycle.
//     -> rd_data[0] = 0xDEAD; next cycle still 0xDEAD from array.
//  3. Port collision: both ports write addr 7 (0x11 on port 0, 0x22 on port 1).
//     -> reads 0x22, same cycle and after.
//  4. Scoreboard: claim r9 -> claim_ok=1, pend_vec[9]=1.
//     A second claim of r9 is refused (claim_ok=0).
//     Release-write r9 = 0x40 -> that cycle rd_busy=0, rd_data=0x40; next cycle pend_vec[9]=0.
//  5. Claim + release of r4 in the same cycle -> claim_ok=1, pend_vec[4]=1 next cycle.
//  6. Reset mid-operation: r2 pending, write r2=0x99 while reset=1.
//     -> next cycle r2 = 0, pend_vec = 0.

Source files
------------

// File: rtl/tinker_regfile_sb_if.sv
// Bus bundle between the tinker_regfile_sb register file and its clients
// (ID stage for reads/claims, WB and long-latency units for writes).
//   slave  : the register file side (drives read data, busy, claim_ok, sp_val, pend_vec)
//   master : the client side (drives read/write addresses, write data, release and claims)
// Packed ports: read port p at rd_addr[p*AW +: AW] / rd_data[p*XLEN +: XLEN],
// write port p at wr_addr[p*AW +: AW] / wr_data[p*XLEN +: XLEN].
interface tinker_regfile_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 3,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_release;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                claim_ok;
  logic [XLEN-1:0]     sp_val;
  logic [NREG-1:0]     pend_vec;

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_release, claim_en, claim_addr,
    output rd_data, rd_busy, claim_ok, sp_val, pend_vec
  );

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_release, claim_en, claim_addr,
    input  rd_data, rd_busy, claim_ok, sp_val, pend_vec
  );
endinterface

// File: rtl/tinker_regfile_sb.sv
// tinker_regfile_sb: multi-port register file with a per-register scoreboard.
// Combinational reads with write-first bypass, synchronous writes, and a pending
// bit per register that is set by an accepted claim and cleared by a releasing write.
// Ports:
//   clk    in  rising-edge clock for all state
//   reset  in  synchronous, active-high; while high the outputs show the reset state
//   bus    slave modport of tinker_regfile_sb_if (reads, writes, claims, sp_val, pend_vec)
module tinker_regfile_sb #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     NREG        = 32,
  parameter int unsigned     NRD         = 3,
  parameter int unsigned     NWR         = 2,
  parameter int unsigned     SP_IDX      = 31,
  parameter logic [XLEN-1:0] SP_INIT     = XLEN'(524288),
  parameter bit              ZERO_REG_EN = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  tinker_regfile_sb_if.slave  bus
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] rel_vec;   // released set R, one-hot per register
  logic [NWR-1:0]  wr_act;    // write enables with the hard-wired zero register masked
  logic            claim_ok;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG_EN && (a == '0);
  endfunction

  function automatic logic [XLEN-1:0] reset_val(input logic [AW-1:0] a);
    return (a == SP_ADDR) ? SP_INIT : '0;
  endfunction

  always_comb begin
    rel_vec = '0;
    wr_act  = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      wr_act[p] = bus.wr_en[p] & ~is_zero(bus.wr_addr[p*AW +: AW]);
      if (wr_act[p] && bus.wr_release[p])
        rel_vec[bus.wr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  // Read ports plus the SP tap share one bypass path: index NRD is the SP read.
  // Ascending port scan lets the highest-index matching writer win.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    bus.sp_val  = '0;
    a = '0;
    v = '0;
    for (int unsigned r = 0; r <= NRD; r++) begin
      a = (r == NRD) ? SP_ADDR : bus.rd_addr[r*AW +: AW];
      if (reset) begin
        v = reset_val(a);
      end else begin
        v = regs_q[a];
        for (int unsigned p = 0; p < NWR; p++)
          if (wr_act[p] && (bus.wr_addr[p*AW +: AW] == a))
            v = bus.wr_data[p*XLEN +: XLEN];
        if (is_zero(a))
          v = '0;
      end
      if (r == NRD) begin
        bus.sp_val = v;
      end else begin
        bus.rd_data[r*XLEN +: XLEN] = v;
        bus.rd_busy[r] = ~reset & pend_q[a] & ~rel_vec[a];
      end
    end
  end

  // A register released this cycle counts as free, so claim + release of the
  // same register is accepted and the claim's set wins over the release's clear.
  always_comb begin
    claim_ok = bus.claim_en &
               (reset | ~(pend_q[bus.claim_addr] & ~rel_vec[bus.claim_addr]));
    pend_d = pend_q & ~rel_vec;
    if (claim_ok && !is_zero(bus.claim_addr))
      pend_d[bus.claim_addr] = 1'b1;
  end

  assign bus.claim_ok = claim_ok;
  assign bus.pend_vec = pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      pend_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++)
        if (wr_act[p])
          regs_q[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Testbench for tinker_regfile_sb: two instances (zero register off / on) share
// the same stimulus and are checked against an array-based reference model.
module tb_tinker_regfile_sb;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 3;
  localparam int unsigned NWR  = 2;
  localparam logic [63:0] SPV  = 64'd524288;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tinker_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if0 ();
  tinker_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if1 ();

  tinker_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .SP_IDX(31),
                      .SP_INIT(64'd524288), .ZERO_REG_EN(1'b0))
    u_dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  tinker_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .SP_IDX(31),
                      .SP_INIT(64'd524288), .ZERO_REG_EN(1'b1))
    u_dut1 (.clk(clk), .reset(rst), .bus(if1.slave));

  // stimulus
  logic [4:0]  ra [3];
  logic [4:0]  wa [2];
  logic [63:0] wd [2];
  logic [1:0]  wen, wrel;
  logic        cen;
  logic [4:0]  ca;

  // reference model: index 0 = plain, 1 = zero register enabled
  logic [63:0] m_regs [2][32];
  logic [31:0] m_pend [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int p = 0; p < 3; p++) begin
      if0.rd_addr[p*5 +: 5] = ra[p];
      if1.rd_addr[p*5 +: 5] = ra[p];
    end
    for (int p = 0; p < 2; p++) begin
      if0.wr_addr[p*5 +: 5]   = wa[p];
      if1.wr_addr[p*5 +: 5]   = wa[p];
      if0.wr_data[p*64 +: 64] = wd[p];
      if1.wr_data[p*64 +: 64] = wd[p];
    end
    if0.wr_en = wen;  if1.wr_en = wen;
    if0.wr_release = wrel;  if1.wr_release = wrel;
    if0.claim_en = cen;  if1.claim_en = cen;
    if0.claim_addr = ca;  if1.claim_addr = ca;
  endtask

  task automatic idle();
    for (int p = 0; p < 3; p++) ra[p] = '0;
    for (int p = 0; p < 2; p++) begin wa[p] = '0; wd[p] = '0; end
    wen = '0; wrel = '0; cen = 1'b0; ca = '0;
  endtask

  function automatic logic released(input logic [4:0] a);
    for (int p = 0; p < 2; p++)
      if (wen[p] && wrel[p] && wa[p] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_read(input int z, input logic [4:0] a);
    logic [63:0] v;
    if (rst) return (a == 5'd31) ? SPV : 64'd0;
    if (z == 1 && a == 5'd0) return 64'd0;
    v = m_regs[z][a];
    for (int p = 0; p < 2; p++)
      if (wen[p] && wa[p] == a) v = wd[p];
    return v;
  endfunction

  function automatic logic exp_busy(input int z, input logic [4:0] a);
    if (rst) return 1'b0;
    return m_pend[z][a] && !released(a);
  endfunction

  function automatic logic exp_claim(input int z);
    if (!cen) return 1'b0;
    if (rst) return 1'b1;
    return !(m_pend[z][ca] && !released(ca));
  endfunction

  function automatic logic [63:0] obs_rd(input int z, input int p);
    return (z == 0) ? if0.rd_data[p*64 +: 64] : if1.rd_data[p*64 +: 64];
  endfunction

  task automatic model_clock();
    logic ok;
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int a = 0; a < 32; a++) m_regs[z][a] = (a == 31) ? SPV : 64'd0;
        m_pend[z] = '0;
      end else begin
        ok = exp_claim(z);
        for (int a = 0; a < 32; a++)
          if (released(5'(a))) m_pend[z][a] = 1'b0;
        if (ok && !(z == 1 && ca == 5'd0)) m_pend[z][ca] = 1'b1;
        for (int p = 0; p < 2; p++)
          if (wen[p] && !(z == 1 && wa[p] == 5'd0)) m_regs[z][wa[p]] = wd[p];
      end
    end
  endtask

  // drive inputs, let them settle, compare every output of both instances
  task automatic settle();
    apply();
    #1;
    for (int z = 0; z < 2; z++) begin
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rd_data z%0d p%0d a%0d", z, p, ra[p]), obs_rd(z, p), exp_read(z, ra[p]));
        chk($sformatf("rd_busy z%0d p%0d a%0d", z, p, ra[p]),
            64'((z == 0) ? if0.rd_busy[p] : if1.rd_busy[p]), 64'(exp_busy(z, ra[p])));
      end
      chk($sformatf("claim_ok z%0d", z), 64'((z == 0) ? if0.claim_ok : if1.claim_ok),
          64'(exp_claim(z)));
      chk($sformatf("sp_val z%0d", z), (z == 0) ? if0.sp_val : if1.sp_val, exp_read(z, 5'd31));
      chk($sformatf("pend_vec z%0d", z), 64'((z == 0) ? if0.pend_vec : if1.pend_vec),
          64'(m_pend[z]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    apply();
    @(negedge clk);
    tick();

    // 1: reset contents
    rst = 1'b0;
    ra[0] = 5'd31; ra[1] = 5'd5;
    settle();
    chk("reset r31", obs_rd(0, 0), 64'd524288);
    chk("reset r5", obs_rd(0, 1), 64'd0);
    chk("reset pend", 64'(if0.pend_vec), 64'd0);
    tick();

    // 2: write-first bypass
    idle(); wen = 2'b01; wa[0] = 5'd3; wd[0] = 64'hDEAD; ra[0] = 5'd3;
    settle();
    chk("bypass r3", obs_rd(0, 0), 64'hDEAD);
    tick();
    idle(); ra[0] = 5'd3;
    settle();
    chk("stored r3", obs_rd(0, 0), 64'hDEAD);
    tick();

    // 3: port collision, higher port wins
    idle(); wen = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 64'h11; wd[1] = 64'h22; ra[0] = 5'd7;
    settle();
    chk("collide bypass r7", obs_rd(0, 0), 64'h22);
    tick();
    idle(); ra[0] = 5'd7;
    settle();
    chk("collide stored r7", obs_rd(0, 0), 64'h22);
    tick();

    // 4: claim, refused re-claim, releasing write
    idle(); cen = 1'b1; ca = 5'd9;
    settle();
    chk("claim r9 ok", 64'(if0.claim_ok), 64'd1);
    tick();
    idle(); cen = 1'b1; ca = 5'd9; ra[0] = 5'd9;
    settle();
    chk("pend r9 set", 64'(if0.pend_vec[9]), 64'd1);
    chk("busy r9", 64'(if0.rd_busy[0]), 64'd1);
    chk("reclaim r9 refused", 64'(if0.claim_ok), 64'd0);
    tick();
    idle(); wen = 2'b01; wrel = 2'b01; wa[0] = 5'd9; wd[0] = 64'h40; ra[0] = 5'd9;
    settle();
    chk("release busy r9", 64'(if0.rd_busy[0]), 64'd0);
    chk("release data r9", obs_rd(0, 0), 64'h40);
    tick();
    idle();
    settle();
    chk("pend r9 clear", 64'(if0.pend_vec[9]), 64'd0);
    tick();

    // 5: claim + release same register in one cycle
    idle(); cen = 1'b1; ca = 5'd4; wen = 2'b01; wrel = 2'b01; wa[0] = 5'd4; wd[0] = 64'h55;
    settle();
    chk("claim+release r4 ok", 64'(if0.claim_ok), 64'd1);
    tick();
    idle();
    settle();
    chk("pend r4 set", 64'(if0.pend_vec[4]), 64'd1);
    tick();

    // zero register: write/claim r0 on both instances
    idle(); wen = 2'b10; wa[1] = 5'd0; wd[1] = 64'h5; cen = 1'b1; ca = 5'd0;
    settle();
    chk("zero claim_ok z1", 64'(if1.claim_ok), 64'd1);
    chk("zero read z1", obs_rd(1, 0), 64'd0);
    tick();

    // 6: reset mid-operation
    idle(); cen = 1'b1; ca = 5'd2;
    settle();
    tick();
    rst = 1'b1; idle(); wen = 2'b01; wa[0] = 5'd2; wd[0] = 64'h99; ra[0] = 5'd2; cen = 1'b1; ca = 5'd2;
    settle();
    chk("in-reset r2", obs_rd(0, 0), 64'd0);
    chk("in-reset claim", 64'(if0.claim_ok), 64'd1);
    tick();
    rst = 1'b0; idle(); ra[0] = 5'd2;
    settle();
    chk("post-reset r2", obs_rd(0, 0), 64'd0);
    chk("post-reset pend", 64'(if0.pend_vec), 64'd0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < 3; p++) ra[p] = raddr();
      for (int p = 0; p < 2; p++) begin
        wa[p] = raddr();
        wd[p] = {$urandom, $urandom};
      end
      wen  = 2'($urandom_range(0, 3));
      wrel = 2'($urandom_range(0, 3));
      cen  = 1'($urandom_range(0, 1));
      ca   = raddr();
      settle();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
